// File: rtl/cordic_pkg.sv
// cordic_pkg: shared FSM type, quadrant codes and binary-angle arctangent table for the CORDIC vectoring engine
package cordic_pkg;

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

    localparam int LUT_W = 18;

    // Quadrant offsets are whole quarter turns, so they only set the top two angle bits.
    // CORDIC_GAIN for 16 steps is ~1.6468; it is left in the magnitude, not divided out.
    localparam logic [1:0] OFF_Q1 = 2'd0;
    localparam logic [1:0] OFF_Q2 = 2'd1;
    localparam logic [1:0] OFF_Q3 = 2'd2;
    localparam logic [1:0] OFF_Q4 = 2'd3;

    function automatic logic [LUT_W-1:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    return 18'd32768;
            5'd1:    return 18'd19344;
            5'd2:    return 18'd10221;
            5'd3:    return 18'd5188;
            5'd4:    return 18'd2604;
            5'd5:    return 18'd1303;
            5'd6:    return 18'd652;
            5'd7:    return 18'd326;
            5'd8:    return 18'd163;
            5'd9:    return 18'd81;
            5'd10:   return 18'd41;
            5'd11:   return 18'd20;
            5'd12:   return 18'd10;
            5'd13:   return 18'd5;
            5'd14:   return 18'd3;
            default: return 18'd1;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_ctrl_microrot.sv
// cordic_microrot: one combinational vectoring micro-rotation, steering y towards zero
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int WX  = 18,
    parameter int W_Z = 18,
    parameter int WI  = 5
) (
    input  logic signed [WX-1:0]  x_in,
    input  logic signed [WX-1:0]  y_in,
    input  logic signed [W_Z-1:0] z_in,
    input  logic        [WI-1:0]  idx,
    output logic signed [WX-1:0]  x_out,
    output logic signed [WX-1:0]  y_out,
    output logic signed [W_Z-1:0] z_out
);

    localparam int SH_L = W_Z >= LUT_W ? W_Z - LUT_W : 0;
    localparam int SH_R = W_Z >= LUT_W ? 0 : LUT_W - W_Z;

    logic signed [WX-1:0]  xs;
    logic signed [WX-1:0]  ys;
    logic signed [31:0]    a_raw;
    logic signed [W_Z-1:0] a;
    logic                  neg;

    always_comb begin
        xs    = x_in >>> idx;
        ys    = y_in >>> idx;
        a_raw = 32'(atan_lut(5'(idx)));
        a     = W_Z'(W_Z >= LUT_W ? a_raw <<< SH_L : a_raw >>> SH_R);
        neg   = y_in[WX-1];
        x_out = neg ? x_in - ys : x_in + ys;
        y_out = neg ? y_in + xs : y_in - xs;
        z_out = neg ? z_in - a : z_in + a;
    end

endmodule

// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl: iterative CORDIC vectoring engine (magnitude/phase) with valid/ready handshakes
module cordic_vec_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = 16,
    parameter int W_IN   = 16,
    parameter int W_Z    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN-1:0]   x_re,
    input  logic [W_IN-1:0]   x_im,
    input  logic [W_Z-1:0]    z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_IN+1:0]   mag_out,
    output logic [W_Z-1:0]    phase_out,
    output logic [2:0]        quadrant_out,
    output logic              busy
);

    localparam int WX = W_IN + 2;
    localparam int WI = $clog2(N_ITER + 1);

    state_t                state_q, state_d;
    logic signed [WX-1:0]  x_q, x_d, y_q, y_d, x_n, y_n;
    logic signed [W_Z-1:0] z_q, z_d, z_n;
    logic [WI-1:0]         i_q, i_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            quad_q, quad_d, qout_q, qout_d;
    logic [WX-1:0]         mag_q, mag_d;
    logic [W_Z-1:0]        phase_q, phase_d;
    logic                  ov_q, ov_d;

    cordic_microrot #(.WX(WX), .W_Z(W_Z), .WI(WI)) u_rot (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .idx   (i_q),
        .x_out (x_n),
        .y_out (y_n),
        .z_out (z_n)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        off_d   = off_q;
        quad_d  = quad_q;
        mag_d   = mag_q;
        phase_d = phase_q;
        qout_d  = qout_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = PRE;
                x_d     = {{2{x_re[W_IN-1]}}, x_re};
                y_d     = {{2{x_im[W_IN-1]}}, x_im};
                z_d     = z_in;
            end
            PRE: begin
                state_d = ITER;
                i_d     = '0;
                // rotate by a multiple of 90 degrees so x >= 0; the extra bits keep -(-32768) exact
                case ({x_q[WX-1], y_q[WX-1]})
                    2'b00: begin quad_d = 3'd1; off_d = OFF_Q1; end
                    2'b01: begin x_d = -y_q; y_d = x_q;  quad_d = 3'd4; off_d = OFF_Q4; end
                    2'b10: begin x_d = y_q;  y_d = -x_q; quad_d = 3'd2; off_d = OFF_Q2; end
                    default: begin x_d = -x_q; y_d = -y_q; quad_d = 3'd3; off_d = OFF_Q3; end
                endcase
            end
            ITER: begin
                x_d = x_n;
                y_d = y_n;
                z_d = z_n;
                i_d = i_q + 1'b1;
                if (i_q == WI'(N_ITER - 1)) state_d = POST;
            end
            POST: begin
                state_d = DONE;
                mag_d   = x_q;
                phase_d = z_q + {off_q, {(W_Z-2){1'b0}}};
                qout_d  = quad_q;
                ov_d    = 1'b1;
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                ov_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            off_q   <= '0;
            quad_q  <= '0;
            mag_q   <= '0;
            phase_q <= '0;
            qout_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            off_q   <= off_d;
            quad_q  <= quad_d;
            mag_q   <= mag_d;
            phase_q <= phase_d;
            qout_q  <= qout_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign out_valid    = ov_q;
    assign mag_out      = mag_q;
    assign phase_out    = phase_q;
    assign quadrant_out = qout_q;

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// tb_cordic_vec_ctrl: randomized bench for cordic_vec_ctrl against an integer CORDIC model and real atan2/hypot
module tb_cordic_vec_ctrl;

    localparam int  N_ITER = 16;
    localparam int  W_IN   = 16;
    localparam int  W_Z    = 18;
    localparam real PI     = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [W_IN-1:0]   x_re = '0;
    logic [W_IN-1:0]   x_im = '0;
    logic [W_Z-1:0]    z_in = '0;
    logic              in_ready, out_valid, busy;
    logic [W_IN+1:0]   mag_out;
    logic [W_Z-1:0]    phase_out;
    logic [2:0]        quadrant_out;

    int  n_chk = 0;
    int  n_fail = 0;
    int  lut [17];
    real gain;

    cordic_vec_ctrl #(.N_ITER(N_ITER), .W_IN(W_IN), .W_Z(W_Z)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x_re         (x_re),
        .x_im         (x_im),
        .z_in         (z_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mag_out      (mag_out),
        .phase_out    (phase_out),
        .quadrant_out (quadrant_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
        n_chk++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int wrapz(input int v);
        int w;
        w = v & ((1 << W_Z) - 1);
        return w >= (1 << (W_Z - 1)) ? w - (1 << W_Z) : w;
    endfunction

    // Integer CORDIC vectoring on plain ints: quarter-turn pre-rotation, then sign-driven micro-rotations
    function automatic void model(input int re, input int im, input int zi,
                                  output int mag, output int ph, output int q);
        int x, y, z, t, off;
        if (re >= 0 && im >= 0) begin x = re;  y = im;  q = 1; off = 0; end
        else if (re >= 0)       begin x = -im; y = re;  q = 4; off = -(1 << (W_Z - 2)); end
        else if (im >= 0)       begin x = im;  y = -re; q = 2; off = 1 << (W_Z - 2); end
        else                    begin x = -re; y = -im; q = 3; off = 1 << (W_Z - 1); end
        z = zi;
        for (int i = 0; i < N_ITER; i++) begin
            t = x;
            if (y >= 0) begin x = x + (y >>> i); y = y - (t >>> i); z = z + lut[i]; end
            else        begin x = x - (y >>> i); y = y + (t >>> i); z = z - lut[i]; end
        end
        mag = x;
        ph  = wrapz(z + off);
    endfunction

    task automatic send(input int re, input int im, input int zi, input int stall,
                        input bit early_ready, input bit hold_iv);
        int  m, p, q, lat, got_m, got_p, ideal_p;
        bit  seen_ready;
        real rad;
        model(re, im, zi, m, p, q);
        x_re = 16'(re);
        x_im = 16'(im);
        z_in = 18'(zi);
        in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 64) begin @(posedge clk); #1; lat++; end
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        if (hold_iv) begin x_re = ~x_re; x_im = 16'($urandom); end
        else in_valid = 1'b0;
        chk("ready_busy_after_accept", {in_ready, busy}, 2'b01);
        out_ready = early_ready;
        lat = 0;
        seen_ready = 1'b0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            seen_ready |= in_ready;
        end
        chk("in_ready_low_while_busy", seen_ready, 0);
        chk("latency", lat, N_ITER + 2);
        got_m = int'($signed(mag_out));
        got_p = int'($signed(phase_out));
        chk("mag", got_m, m);
        chk("phase", got_p, p);
        chk("quadrant", quadrant_out, q);
        rad = $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
        if (rad >= 4096.0) begin
            ideal_p = int'($atan2(real'(im), real'(re)) * 131072.0 / PI) + zi;
            chk("mag_vs_hypot", got_m, int'(gain * rad), 48);
            chk("phase_vs_atan2", ideal_p + wrapz(got_p - ideal_p), ideal_p, 256);
        end
        if (!early_ready) begin
            repeat (stall) begin
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_mag", int'($signed(mag_out)), m);
                chk("hold_phase", int'($signed(phase_out)), p);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("valid_clear_after_ready", out_valid, 0);
        chk("idle_after_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        real r;
        int  re, im, zi;
        bit  early, seen;
        r = 1.0;
        gain = 1.0;
        for (int i = 0; i < 17; i++) begin
            lut[i] = $rtoi($floor($atan(r) * 131072.0 / PI + 0.5));
            if (i < N_ITER) gain = gain * $sqrt(1.0 + r * r);
            r = r / 2.0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mag", mag_out, 0);
        chk("rst_phase", phase_out, 0);
        chk("rst_quadrant", quadrant_out, 0);
        rst = 1'b0;

        send(1000, 0, 0, 3, 1'b0, 1'b0);
        send(-1000, 0, 0, 0, 1'b1, 1'b0);
        send(0, -1000, 0, 10, 1'b0, 1'b1);
        send(-32768, -32768, 0, 2, 1'b0, 1'b0);
        send(0, 0, 500, 1, 1'b0, 1'b0);
        send(32767, 32767, -1000, 0, 1'b0, 1'b0);
        send(-32768, 0, 131071, 1, 1'b1, 1'b0);
        send(0, -32768, -131072, 2, 1'b0, 1'b1);
        send(-1, 32767, 12345, 0, 1'b0, 1'b0);

        // abort a sample part-way through the micro-rotations
        x_re = 16'd20000;
        x_im = 16'd3000;
        z_in = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_before_abort", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        seen = 1'b0;
        repeat (N_ITER + 6) begin @(posedge clk); #1; seen |= out_valid; end
        chk("abort_no_output", seen, 0);
        send(0, 1000, 0, 0, 1'b0, 1'b0);
        chk("post_abort_phase", int'($signed(phase_out)), 65536, 64);

        for (int k = 0; k < 2000; k++) begin
            if (k % 8 == 0) begin
                re = $urandom_range(0, 64) - 32;
                im = $urandom_range(0, 64) - 32;
            end else begin
                re = $urandom_range(0, 65535) - 32768;
                im = $urandom_range(0, 65535) - 32768;
            end
            zi = $urandom_range(0, 262143) - 131072;
            early = $urandom_range(0, 3) == 0;
            send(re, im, zi, $urandom_range(0, 3), early, !early && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
